// File: rtl/cnn_pkg.sv
// Shared fp16 constants, pool FSM state type and fp16 ranking helper.
package cnn_pkg;

  localparam int          FP16_W       = 16;
  localparam logic [4:0]  FP16_NAN_EXP = 5'h1F;
  localparam logic [15:0] FP16_ZERO    = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVEN  = 2'd1,
    ODD   = 2'd2,
    DRAIN = 2'd3
  } pool_state_t;

  // Map an fp16 value onto an unsigned key whose ordering matches numeric
  // ordering. NaN maps to 0 (below every number); -0 is folded onto +0 so
  // both zeros produce the same key.
  function automatic logic [16:0] fp16_rank(input logic [FP16_W-1:0] v);
    logic [15:0] z;
    logic [16:0] k;
    z = v;
    if ((v[14:10] == FP16_NAN_EXP) && (v[9:0] != 10'h000)) begin
      k = 17'h0_0000;
    end else begin
      if (v[14:0] == 15'h0000) begin
        z = FP16_ZERO;
      end else begin
        z = v;
      end
      if (z[15]) begin
        k = {1'b1, ~z};
      end else begin
        k = {1'b1, z | 16'h8000};
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/max.sv
// Combinational fp16 4-input max. NaN loses to any number, +0 == -0, and on
// equal rank the later operand wins.
module max (
  input  logic [15:0] n1,
  input  logic [15:0] n2,
  input  logic [15:0] n3,
  input  logic [15:0] n4,
  output logic [15:0] y
);
  import cnn_pkg::*;

  logic [FP16_W-1:0] best;

  // Left-to-right fold; ">=" makes the later operand win ties.
  always_comb begin
    best = n1;
    if (fp16_rank(n2) >= fp16_rank(best)) begin
      best = n2;
    end else begin
      best = best;
    end
    if (fp16_rank(n3) >= fp16_rank(best)) begin
      best = n3;
    end else begin
      best = best;
    end
    if (fp16_rank(n4) >= fp16_rank(best)) begin
      best = n4;
    end else begin
      best = best;
    end
    y = best;
  end

endmodule

// File: rtl/pool_linebuf.sv
// Single-write / single-read row buffer. Write is clocked, read is
// asynchronous so it maps to distributed RAM or plain registers.
module pool_linebuf #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Store one pixel of the even row; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_ctrl.sv
// Streaming 2x2 stride-2 fp16 max-pool controller. The even row is parked in
// a line buffer; during the odd row the top-left pixel and the bottom-left
// pixel of each window are held so the window resolves on the odd-column beat.
module maxpool2x2_ctrl #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int DATA_WIDTH = 16,
  parameter int COL_W      = $clog2(IMG_W),
  parameter int ROW_W      = $clog2(IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  import cnn_pkg::*;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  pool_state_t       state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [15:0]       hold_top;
  logic [15:0]       hold_bot;
  logic [15:0]       lb_rdata;
  logic [15:0]       max_y;
  logic              in_beat;
  logic              out_beat;
  logic              lb_we;
  logic              load;

  assign in_beat  = in_valid && in_ready;
  assign out_beat = out_valid && out_ready;
  assign lb_we    = (state == EVEN) && in_beat;
  assign load     = (state == ODD) && in_beat && col[0];

  pool_linebuf #(
    .DEPTH (IMG_W),
    .AW    (COL_W),
    .DW    (16)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (col),
    .wdata (in_data),
    .raddr (col),
    .rdata (lb_rdata)
  );

  max u_max (
    .n1 (hold_top),
    .n2 (lb_rdata),
    .n3 (hold_bot),
    .n4 (in_data),
    .y  (max_y)
  );

  // Input acceptance: the odd-column beat of an odd row is the only one that
  // produces a result, so only it waits for room in the output register.
  always_comb begin
    in_ready = 1'b0;
    if (!rst_n) begin
      in_ready = 1'b0;
    end else begin
      case (state)
        IDLE:    in_ready = 1'b0;
        EVEN:    in_ready = 1'b1;
        ODD: begin
          if (col[0]) begin
            in_ready = !out_valid || out_ready;
          end else begin
            in_ready = 1'b1;
          end
        end
        DRAIN:   in_ready = 1'b0;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Frame sequencing, window hold registers and the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      hold_top  <= FP16_ZERO;
      hold_bot  <= FP16_ZERO;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= FP16_ZERO;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= EVEN;
            busy  <= 1'b1;
            col   <= '0;
            row   <= '0;
          end
        end
        EVEN: begin
          if (in_beat) begin
            if (col == LAST_COL) begin
              col   <= '0;
              row   <= row + ROW_W'(1);
              state <= ODD;
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        ODD: begin
          if (in_beat) begin
            if (!col[0]) begin
              hold_top <= lb_rdata;
              hold_bot <= in_data;
            end
            if (col == LAST_COL) begin
              col <= '0;
              if (row == LAST_ROW) begin
                state <= DRAIN;
              end else begin
                row   <= row + ROW_W'(1);
                state <= EVEN;
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_beat) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        out_data  <= max_y;
        out_valid <= 1'b1;
      end else if (out_beat) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
